// File: rtl/bnn_feature_loader_if.sv
// Feature-in and result-out valid/ready streams of bnn_feature_loader.
// slave: loader side; master: source/sink side.
interface bnn_feature_loader_if #(
  parameter int FEAT_BITS = 4,
  parameter int CLS_W     = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [FEAT_BITS-1:0] in_feat;
  logic                 out_valid;
  logic                 out_ready;
  logic [CLS_W-1:0]     out_class;

  modport slave (
    input  in_valid, in_feat, out_ready,
    output in_ready, out_valid, out_class
  );

  modport master (
    output in_valid, in_feat, out_ready,
    input  in_ready, out_valid, out_class
  );
endinterface

// File: rtl/bnn_feature_loader.sv
// Feeds a sequential BNN classifier: assembles features, restarts it,
// waits CLASSIFY_CYCLES, captures prediction and hands it downstream.
// Ports: clk, rst (sync, active-high), bus (feature in / class out
// streams), features, clf_rst, pred_in, result_cnt.
module bnn_feature_loader #(
  parameter int FEAT_CNT        = 19,
  parameter int FEAT_BITS       = 4,
  parameter int CLASS_CNT       = 3,
  parameter int CLASSIFY_CYCLES = 45,
  parameter int CNT_BITS        = 16,
  localparam int CLS_W =
    (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  bnn_feature_loader_if.slave           bus,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          clf_rst,
  input  logic [CLS_W-1:0]              pred_in,
  output logic [CNT_BITS-1:0]           result_cnt
);

  localparam int IW = $clog2(FEAT_CNT + 1);
  localparam int WW = $clog2(CLASSIFY_CYCLES + 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_OUT
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [IW-1:0]                 r_idx;
  logic [WW-1:0]                 r_wait;
  logic [FEAT_CNT*FEAT_BITS-1:0] r_feat;
  logic [CLS_W-1:0]              r_cls;
  logic [CNT_BITS-1:0]           r_cnt;

  logic w_acc;
  logic w_last;
  logic w_done;
  logic w_hs;

  assign w_acc  = (r_state == S_LOAD) && bus.in_valid;
  assign w_last = (r_idx == IW'(FEAT_CNT - 1));
  assign w_done = (r_state == S_RUN) &&
                  (r_wait == WW'(CLASSIFY_CYCLES - 1));
  assign w_hs   = (r_state == S_OUT) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD:  if (w_acc && w_last) w_next = S_RUN;
      S_RUN:   if (w_done)          w_next = S_OUT;
      S_OUT:   if (bus.out_ready)   w_next = S_LOAD;
      default:                      w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_wait <= '0;
      r_feat <= '0;
      r_cls  <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_acc) begin
        for (int k = 0; k < FEAT_CNT; k++) begin
          if (r_idx == IW'(k))
            r_feat[k*FEAT_BITS +: FEAT_BITS] <= bus.in_feat;
        end
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      if (r_state == S_RUN)
        r_wait <= w_done ? '0 : r_wait + 1'b1;
      if (w_done)
        r_cls <= pred_in;
      if (w_hs)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // rst gating keeps in_ready low during reset even before the
  // state register has settled; no path from in_valid/out_ready.
  assign bus.in_ready  = (r_state == S_LOAD) && !rst;
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.out_class = r_cls;

  // r_wait is 0 only in the first RUN cycle.
  assign clf_rst    = rst || ((r_state == S_RUN) && (r_wait == '0));
  assign features   = r_feat;
  assign result_cnt = r_cnt;

endmodule
